// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: multi-cycle WIDTH-bit adder, one 3-bit CLA slice per clock.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b, cin operand
// handshake; out_valid/out_ready + sum, cout, ovf result handshake; busy in RUN/DONE.
module cla_slice_sequencer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 3;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    generate
        if (WIDTH < 3 || (WIDTH % 3) != 0) begin : g_bad_width
            $error("cla_slice_sequencer: WIDTH must be a positive multiple of 3");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nx;
    logic [IW-1:0]    idx_q;
    logic             carry_q, cout_q, ovf_q;

    logic [2:0] a_sl, b_sl, g, p, s;
    logic       c1, c2, c3;
    logic       accept, step, last;

    // Select the active slice of the latched operands.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                a_sl = a_q[3*i +: 3];
                b_sl = b_q[3*i +: 3];
            end
        end
    end

    // 3-bit carry look-ahead slice.
    always_comb begin
        g  = a_sl & b_sl;
        p  = a_sl ^ b_sl;
        c1 = g[0] | (p[0] & carry_q);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry_q);
        s  = p ^ {c2, c1, carry_q};
    end

    always_comb begin
        sum_nx = sum_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                sum_nx[3*i +: 3] = s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx_q == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == RUN);
    assign last   = (idx_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= cin;
        end else if (step) begin
            sum_q   <= sum_nx;
            carry_q <= c3;
            if (last) begin
                // c2 of the top slice is the carry into the MSB.
                cout_q <= c3;
                ovf_q  <= c3 ^ c2;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
